// File: rtl/sdram_axi_pkg.sv
// sdram_axi_pkg: state encoding and AXI constants shared by the SDRAM line reader.
package sdram_axi_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
endpackage

// File: rtl/sdram_line_fifo.sv
// sdram_line_fifo: synchronous show-ahead FIFO; head word is visible on data_o whenever not empty.
module sdram_line_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_pop;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = occupancy_o == CW'(DEPTH);
    assign empty_o = occupancy_o == '0;
    assign data_o  = empty_o ? '0 : mem[rd_ptr];
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy_o <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            occupancy_o <= occupancy_o + CW'(push_i) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= data_i;
    end
    // The reader reserves space before each burst, so a write into a full FIFO is a design bug.
    assert property (@(posedge clk_i) disable iff (!rst_i) !(push_i && full_o));
endmodule

// File: rtl/sdram_axi_line_reader.sv
// sdram_axi_line_reader: read-only AXI4 INCR burst master streaming a contiguous word block through a FIFO.
module sdram_axi_line_reader
    import sdram_axi_pkg::*;
#(
    parameter int          FIFO_DEPTH = 32,
    parameter int          BURST_LEN  = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_count_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        outport_arvalid_o,
    input  logic        outport_arready_i,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_rvalid_i,
    output logic        outport_rready_o,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        data_valid_o,
    output logic [31:0] data_o,
    input  logic        data_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t        state, state_nxt;
    logic [31:0]   addr;
    logic [15:0]   remaining;
    logic [CW-1:0] reserved, occupancy, free;
    logic [4:0]    cur_len, burst_len, beat;
    logic          fifo_empty, fifo_full, ar_hs, r_beat, last_beat, beat_err, pop;
    assign cur_len   = (remaining > 16'(BURST_LEN)) ? 5'(BURST_LEN) : remaining[4:0];
    assign free      = CW'(FIFO_DEPTH) - occupancy - reserved;
    assign ar_hs     = outport_arvalid_o && outport_arready_i;
    assign r_beat    = state == DATA && outport_rvalid_i;
    assign last_beat = beat + 5'd1 == burst_len;
    assign beat_err  = outport_rresp_i != AXI_RESP_OKAY || outport_rid_i != AXI_ID || outport_rlast_i != last_beat;
    assign pop       = data_valid_o && data_ready_i;
    assign data_valid_o      = !fifo_empty;
    assign outport_araddr_o  = addr;
    assign outport_arid_o    = AXI_ID;
    assign outport_arburst_o = AXI_BURST_INCR;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end
    // FLUSH exits on the cycle the last word leaves, so done_o lands one cycle after that handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = word_count_i == '0 ? FLUSH : ADDR;
            ADDR:    if (ar_hs) state_nxt = DATA;
            DATA:    if (r_beat && last_beat) state_nxt = remaining != '0 ? ADDR : FLUSH;
            FLUSH:   if (fifo_empty || (occupancy == CW'(1) && pop)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        outport_arvalid_o = state == ADDR && 32'(free) >= 32'(cur_len);
        outport_arlen_o   = state == ADDR ? 8'(cur_len - 5'd1) : '0;
        outport_rready_o  = state == DATA || state == IDLE;
        busy_o            = state != IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr      <= '0;
            remaining <= '0;
            reserved  <= '0;
            burst_len <= '0;
            beat      <= '0;
            error_o   <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= state == FLUSH && state_nxt == IDLE;
            if (state == IDLE && start_i) begin
                addr      <= {base_addr_i[31:2], 2'b00};
                remaining <= word_count_i;
                error_o   <= 1'b0;
            end
            if (ar_hs) begin
                reserved  <= reserved + CW'(cur_len);
                addr      <= addr + {25'd0, cur_len, 2'b00};
                remaining <= remaining - 16'(cur_len);
                burst_len <= cur_len;
                beat      <= '0;
            end
            if (r_beat) begin
                reserved <= reserved - 1'b1;
                beat     <= beat + 5'd1;
                if (beat_err) error_o <= 1'b1;
            end
        end
    end
    sdram_line_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (r_beat),
        .data_i      (outport_rdata_i),
        .pop_i       (pop),
        .data_o      (data_o),
        .occupancy_o (occupancy),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );
endmodule

// File: tb/tb_sdram_axi_line_reader.sv
// tb_sdram_axi_line_reader: directed bench with an AXI read slave model whose data is address + 0x1000_0000.
module tb_sdram_axi_line_reader;
    logic        clk = 0, rst_n = 0, start = 0, data_ready = 1;
    logic [31:0] base = 0;
    logic [15:0] count = 0;
    logic        busy, done, error, arvalid, arready, rvalid, rready, rlast, data_valid;
    logic [31:0] araddr, rdata, data;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [1:0]  arburst, rresp;

    sdram_axi_line_reader dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .base_addr_i(base), .word_count_i(count),
        .busy_o(busy), .done_o(done), .error_o(error),
        .outport_arvalid_o(arvalid), .outport_arready_i(arready), .outport_araddr_o(araddr),
        .outport_arid_o(arid), .outport_arlen_o(arlen), .outport_arburst_o(arburst),
        .outport_rvalid_i(rvalid), .outport_rready_o(rready), .outport_rdata_i(rdata),
        .outport_rresp_i(rresp), .outport_rid_i(rid), .outport_rlast_i(rlast),
        .data_valid_o(data_valid), .data_o(data), .data_ready_i(data_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    int start_cyc, done_cyc, last_hs_edge, done_cnt = 0, busy_cnt = 0;
    logic [31:0] got[$];
    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    int beats_left = 0, beat_idx = 0, cur_burst = -1, err_burst = -1, err_beat = 0;
    int ar_delay = 0, ar_wait = 0, arv_cycles = 0, stab_err = 0;
    logic [31:0] beat_addr = 0, held_addr = 0, hs_addr = 0;
    logic [7:0]  held_len = 0, hs_len = 0;
    bit ar_hs = 0, r_hs = 0, ar_held = 0;

    // AXI read slave: drives at negedge, handshakes resolve at the following posedge.
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
                beats_left = 0; ar_hs = 0; r_hs = 0; ar_wait = 0; ar_held = 0;
                continue;
            end
            if (ar_hs) begin
                ar_addr_log.push_back(hs_addr);
                ar_len_log.push_back(hs_len);
                cur_burst = ar_addr_log.size() - 1;
                beat_addr = hs_addr; beats_left = int'(hs_len) + 1; beat_idx = 0;
                ar_wait = 0; ar_held = 0;
            end
            if (r_hs) begin
                beat_addr += 4; beats_left--; beat_idx++;
            end
            if (arvalid) begin
                if (ar_held && (araddr !== held_addr || arlen !== held_len)) stab_err++;
                ar_held = 1; held_addr = araddr; held_len = arlen; arv_cycles++;
            end
            arready = arvalid && beats_left == 0 && ar_wait >= ar_delay;
            if (arvalid && !arready) ar_wait++;
            rvalid = beats_left > 0;
            rdata  = beat_addr + 32'h1000_0000;
            rlast  = beats_left == 1;
            rresp  = (rvalid && cur_burst == err_burst && beat_idx == err_beat) ? 2'b10 : 2'b00;
            rid    = 0;
            #1;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (ar_hs) begin hs_addr = araddr; hs_len = arlen; end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && data_valid && data_ready) begin
            got.push_back(data);
            last_hs_edge = cyc + 1;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_arvalid"}, 32'(arvalid), 0);
        chk({p, "_araddr"}, araddr, 0);
        chk({p, "_arlen"}, 32'(arlen), 0);
        chk({p, "_arburst"}, 32'(arburst), 1);
        chk({p, "_arid"}, 32'(arid), 0);
        chk({p, "_data_valid"}, 32'(data_valid), 0);
        chk({p, "_data_o"}, data, 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_error"}, 32'(error), 0);
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        @(negedge clk); base = b; count = n; start = 1; start_cyc = cyc;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_done(input int d0, input int lim, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < lim) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        #3;
        chk(tag, 32'(done_cnt - d0), 1);
    endtask

    function automatic int bad_words(input int g0, input int n, input logic [31:0] b);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (g0 + i >= got.size() || got[g0 + i] !== b + 32'(4 * i) + 32'h1000_0000) bad++;
        return bad;
    endfunction

    initial begin
        int d0, g0, a0, b0, n0, k;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        @(negedge clk); rst_n = 1;
        @(negedge clk);

        // three bursts 8/8/4 from 0x100
        d0 = done_cnt; g0 = got.size(); n0 = ar_addr_log.size();
        do_start(32'h100, 20);
        chk("a_first_arvalid", 32'(arvalid), 1);
        chk("a_busy", 32'(busy), 1);
        wait_done(d0, 400, "a_done_once");
        chk("a_bursts", 32'(ar_addr_log.size() - n0), 3);
        chk("a_addr0", ar_addr_log[n0], 32'h100);
        chk("a_addr1", ar_addr_log[n0 + 1], 32'h120);
        chk("a_addr2", ar_addr_log[n0 + 2], 32'h140);
        chk("a_len0", 32'(ar_len_log[n0]), 7);
        chk("a_len1", 32'(ar_len_log[n0 + 1]), 7);
        chk("a_len2", 32'(ar_len_log[n0 + 2]), 3);
        chk("a_nwords", 32'(got.size() - g0), 20);
        chk("a_words", 32'(bad_words(g0, 20, 32'h100)), 0);
        chk("a_error", 32'(error), 0);
        chk("a_done_timing", 32'(done_cyc), 32'(last_hs_edge));
        chk("a_idle_busy", 32'(busy), 0);

        // zero-length request
        d0 = done_cnt; b0 = busy_cnt; a0 = arv_cycles;
        do_start(32'h700, 0);
        wait_done(d0, 20, "z_done_once");
        chk("z_done_cycle", 32'(done_cyc), 32'(start_cyc + 2));
        chk("z_busy_cycles", 32'(busy_cnt - b0), 1);
        chk("z_no_arvalid", 32'(arv_cycles - a0), 0);

        // consumer stalled: reservation limits issue to four bursts
        data_ready = 0;
        d0 = done_cnt; g0 = got.size(); n0 = ar_addr_log.size();
        do_start(32'h1000, 64);
        repeat (150) @(negedge clk);
        chk("b_bursts_stalled", 32'(ar_addr_log.size() - n0), 4);
        chk("b_arvalid_low", 32'(arvalid), 0);
        chk("b_head_valid", 32'(data_valid), 1);
        chk("b_head_data", data, 32'h1000_1000);
        chk("b_no_words", 32'(got.size() - g0), 0);
        data_ready = 1;
        wait_done(d0, 600, "b_done_once");
        chk("b_bursts_total", 32'(ar_addr_log.size() - n0), 8);
        chk("b_nwords", 32'(got.size() - g0), 64);
        chk("b_words", 32'(bad_words(g0, 64, 32'h1000)), 0);
        chk("b_error", 32'(error), 0);

        // SLVERR on beat 3 of the second burst
        d0 = done_cnt; g0 = got.size();
        err_burst = ar_addr_log.size() + 1; err_beat = 3;
        do_start(32'h2000, 20);
        wait_done(d0, 400, "e_done_once");
        err_burst = -1;
        chk("e_error_held", 32'(error), 1);
        chk("e_nwords", 32'(got.size() - g0), 20);
        chk("e_words", 32'(bad_words(g0, 20, 32'h2000)), 0);
        d0 = done_cnt;
        do_start(32'h2100, 0);
        chk("e_error_cleared", 32'(error), 0);
        wait_done(d0, 20, "e_clear_done");

        // slow arready
        ar_delay = 5;
        d0 = done_cnt; g0 = got.size(); n0 = ar_addr_log.size(); a0 = arv_cycles;
        do_start(32'h300, 8);
        wait_done(d0, 200, "d_done_once");
        ar_delay = 0;
        chk("d_bursts", 32'(ar_addr_log.size() - n0), 1);
        chk("d_addr", ar_addr_log[n0], 32'h300);
        chk("d_len", 32'(ar_len_log[n0]), 7);
        chk("d_arvalid_cycles", 32'(arv_cycles - a0), 6);
        chk("d_stable", 32'(stab_err), 0);
        chk("d_words", 32'(bad_words(g0, 8, 32'h300)), 0);

        // asynchronous reset mid-burst, then a short clean read
        g0 = got.size();
        do_start(32'h400, 16);
        k = 0;
        while (got.size() - g0 < 3 && k < 100) begin @(negedge clk); k++; end
        chk("r_progress", 32'(got.size() - g0 >= 3), 1);
        #3 rst_n = 0;
        #1 reset_checks("r_mid");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        d0 = done_cnt; g0 = got.size();
        do_start(32'h500, 4);
        wait_done(d0, 100, "r_done_once");
        chk("r_nwords", 32'(got.size() - g0), 4);
        chk("r_words", 32'(bad_words(g0, 4, 32'h500)), 0);
        chk("r_error", 32'(error), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
